// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, fetch state encoding and opcode map
// used by both the decoder and the fetch unit.
package cpu_pkg;

    localparam int PC_W  = 16;
    localparam int OPC_W = 5;

    typedef enum logic [1:0] {
        FS_FETCH = 2'd0,
        FS_FULL  = 2'd1,
        FS_DRAIN = 2'd2
    } fetch_state_e;

    // Plain-vector copies of the state encoding for code that stores state as logic.
    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_FULL  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [OPC_W-1:0] OPC_NOP = 5'h00;
    localparam logic [OPC_W-1:0] OPC_ALU = 5'h01;
    localparam logic [OPC_W-1:0] OPC_LD  = 5'h02;
    localparam logic [OPC_W-1:0] OPC_ST  = 5'h03;
    localparam logic [OPC_W-1:0] OPC_B   = 5'h10;
    localparam logic [OPC_W-1:0] OPC_BEQ = 5'h11;
    localparam logic [OPC_W-1:0] OPC_JMP = 5'h12;
    localparam logic [OPC_W-1:0] OPC_FUN = 5'h13;
    localparam logic [OPC_W-1:0] OPC_RET = 5'h14;

    function automatic logic [OPC_W-1:0] opcode_of(input logic [PC_W-1:0] word);
        return word[PC_W-1 -: OPC_W];
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read channel: one request held until the memory signals ready,
// with the read data valid in that same ready cycle.
interface fetch_unit_if;
    import cpu_pkg::*;

    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_rdy;
    logic [PC_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdy,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdy,
        output imem_rdata
    );

endinterface

// File: rtl/br_target.sv
// Combinational redirect selection for the instruction in decode:
// RET beats JMP beats taken BEQ beats B; relative targets are PC-relative to inst_pc+1.
module br_target
    import cpu_pkg::*;
(
    input  logic [PC_W-1:0] inst_pc,
    input  logic [PC_W-1:0] br_off,
    input  logic [PC_W-1:0] jmp_tgt,
    input  logic [PC_W-1:0] ret_addr,
    input  logic            b_en,
    input  logic            beq_en,
    input  logic            jmp_en,
    input  logic            ret_en,
    input  logic            zero,
    output logic            redirect,
    output logic [PC_W-1:0] target
);

    logic [PC_W-1:0] rel_tgt;

    // Relative target wraps naturally at 16 bits, so backward offsets just add.
    always_comb begin
        rel_tgt  = inst_pc + {{(PC_W-1){1'b0}}, 1'b1} + br_off;
        redirect = 1'b0;
        target   = rel_tgt;
        if (ret_en) begin
            redirect = 1'b1;
            target   = ret_addr;
        end else if (jmp_en) begin
            redirect = 1'b1;
            target   = jmp_tgt;
        end else if (beq_en && zero) begin
            redirect = 1'b1;
            target   = rel_tgt;
        end else if (b_en) begin
            redirect = 1'b1;
            target   = rel_tgt;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Single-entry instruction fetch stage: issues one memory read at a time, buffers the
// returned word for decode, and handles branch redirects and interrupt entry.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 16'h0000,
    parameter logic [PC_W-1:0] INTR_VEC = 16'h0002
) (
    input  logic              clk,
    input  logic              rst_n,
    fetch_unit_if.master      imem,
    output logic              inst_valid,
    output logic [PC_W-1:0]   inst,
    output logic [PC_W-1:0]   inst_pc,
    input  logic              stall,
    input  logic              B,
    input  logic              BEQ,
    input  logic              JMP,
    input  logic              RET,
    input  logic              zero,
    input  logic [PC_W-1:0]   br_off,
    input  logic [PC_W-1:0]   jmp_tgt,
    input  logic [PC_W-1:0]   ret_addr,
    input  logic              intr,
    output logic [PC_W-1:0]   ilr
);

    logic [1:0]      state_q,    state_d;
    logic [PC_W-1:0] req_addr_q, req_addr_d;
    logic [PC_W-1:0] pc_q,       pc_d;
    logic [PC_W-1:0] inst_q,     inst_d;
    logic [PC_W-1:0] inst_pc_q,  inst_pc_d;
    logic [PC_W-1:0] ilr_q,      ilr_d;

    logic            consume;
    logic            redirect;
    logic [PC_W-1:0] target;

    br_target u_br_target (
        .inst_pc  (inst_pc_q),
        .br_off   (br_off),
        .jmp_tgt  (jmp_tgt),
        .ret_addr (ret_addr),
        .b_en     (B),
        .beq_en   (BEQ),
        .jmp_en   (JMP),
        .ret_en   (RET),
        .zero     (zero),
        .redirect (redirect),
        .target   (target)
    );

    // Request is gated by rst_n so the bus goes quiet the instant reset asserts.
    assign inst_valid     = (state_q == ST_FULL);
    assign imem.imem_req  = rst_n && (state_q != ST_FULL);
    assign imem.imem_addr = req_addr_q;
    assign inst           = inst_q;
    assign inst_pc        = inst_pc_q;
    assign ilr            = ilr_q;
    assign consume        = inst_valid && !stall;

    always_comb begin
        state_d    = state_q;
        req_addr_d = req_addr_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        inst_pc_d  = inst_pc_q;
        ilr_d      = ilr_q;
        case (state_q)
            ST_FETCH: begin
                if (imem.imem_rdy) begin
                    if (intr) begin
                        ilr_d      = req_addr_q;
                        req_addr_d = INTR_VEC;
                    end else begin
                        inst_d    = imem.imem_rdata;
                        inst_pc_d = req_addr_q;
                        pc_d      = req_addr_q + {{(PC_W-1){1'b0}}, 1'b1};
                        state_d   = ST_FULL;
                    end
                end else if (intr) begin
                    // The read cannot be withdrawn, so wait it out before vectoring.
                    ilr_d   = req_addr_q;
                    state_d = ST_DRAIN;
                end
            end
            ST_FULL: begin
                if (intr) begin
                    ilr_d      = inst_pc_q;
                    req_addr_d = INTR_VEC;
                    state_d    = ST_FETCH;
                end else if (consume) begin
                    req_addr_d = redirect ? target : pc_q;
                    state_d    = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (imem.imem_rdy) begin
                    req_addr_d = INTR_VEC;
                    state_d    = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_FETCH;
            req_addr_q <= RESET_PC;
            pc_q       <= RESET_PC;
            inst_q     <= '0;
            inst_pc_q  <= '0;
            ilr_q      <= '0;
        end else begin
            state_q    <= state_d;
            req_addr_q <= req_addr_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            inst_pc_q  <= inst_pc_d;
            ilr_q      <= ilr_d;
        end
    end

    // A stalled read must keep its address, and decode never overlaps a request.
    a_addr_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (imem.imem_req && !imem.imem_rdy) |=> (imem.imem_addr == $past(imem.imem_addr)));

    a_one_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
        !(inst_valid && imem.imem_req));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a transaction-level model tracks the buffer and the
// outstanding read, a negedge process compares against it, and literal checks pin key cases.
module tb_fetch_unit;

    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam logic [15:0] INTR_VEC = 16'h0002;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rdy_en;
    logic        inst_valid;
    logic [15:0] inst, inst_pc, ilr;
    logic        stall, b_s, beq_s, jmp_s, ret_s, zero, intr;
    logic [15:0] br_off, jmp_tgt, ret_addr;

    int pass_cnt = 0;
    int total_cnt = 0;

    fetch_unit_if imem_bus ();

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (a == 16'h0000) return 16'h1234;
        return {a[7:0], a[15:8]} ^ 16'h5A5A;
    endfunction

    assign imem_bus.imem_rdy   = rdy_en;
    assign imem_bus.imem_rdata = mem_word(imem_bus.imem_addr);

    fetch_unit #(.RESET_PC(RESET_PC), .INTR_VEC(INTR_VEC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem       (imem_bus),
        .inst_valid (inst_valid),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .stall      (stall),
        .B          (b_s),
        .BEQ        (beq_s),
        .JMP        (jmp_s),
        .RET        (ret_s),
        .zero       (zero),
        .br_off     (br_off),
        .jmp_tgt    (jmp_tgt),
        .ret_addr   (ret_addr),
        .intr       (intr),
        .ilr        (ilr)
    );

    task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("[TB] FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    // Model: a one-slot buffer that is either holding an instruction or waiting on one read.
    bit          m_full = 1'b0;
    bit          m_drain = 1'b0;
    logic [15:0] m_addr = RESET_PC;
    logic [15:0] m_seq = RESET_PC;
    logic [15:0] m_inst = 16'h0000;
    logic [15:0] m_inst_pc = 16'h0000;
    logic [15:0] m_ilr = 16'h0000;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_full = 1'b0; m_drain = 1'b0; m_addr = RESET_PC; m_seq = RESET_PC;
            m_inst = 16'h0000; m_inst_pc = 16'h0000; m_ilr = 16'h0000;
        end else if (!m_full) begin
            if (rdy_en) begin
                if (m_drain) begin
                    m_drain = 1'b0;
                    m_addr  = INTR_VEC;
                end else if (intr) begin
                    m_ilr  = m_addr;
                    m_addr = INTR_VEC;
                end else begin
                    m_inst    = mem_word(m_addr);
                    m_inst_pc = m_addr;
                    m_seq     = m_addr + 16'd1;
                    m_full    = 1'b1;
                end
            end else if (intr && !m_drain) begin
                m_ilr   = m_addr;
                m_drain = 1'b1;
            end
        end else if (intr) begin
            m_ilr  = m_inst_pc;
            m_addr = INTR_VEC;
            m_full = 1'b0;
        end else if (!stall) begin
            if (ret_s)              m_addr = ret_addr;
            else if (jmp_s)         m_addr = jmp_tgt;
            else if (beq_s && zero) m_addr = m_inst_pc + 16'd1 + br_off;
            else if (b_s)           m_addr = m_inst_pc + 16'd1 + br_off;
            else                    m_addr = m_seq;
            m_full = 1'b0;
        end
    end

    always @(negedge clk) begin
        check_output("cmp_req",     {15'd0, imem_bus.imem_req}, {15'd0, rst_n && !m_full});
        if (rst_n && !m_full) check_output("cmp_addr", imem_bus.imem_addr, m_addr);
        check_output("cmp_valid",   {15'd0, inst_valid}, {15'd0, m_full});
        check_output("cmp_inst",    inst, m_inst);
        check_output("cmp_inst_pc", inst_pc, m_inst_pc);
        check_output("cmp_ilr",     ilr, m_ilr);
    end

    initial begin
        rdy_en = 1'b1; stall = 1'b0; intr = 1'b0; zero = 1'b0;
        b_s = 1'b0; beq_s = 1'b0; jmp_s = 1'b0; ret_s = 1'b0;
        br_off = 16'h0000; jmp_tgt = 16'h0000; ret_addr = 16'h0000;

        repeat (2) next_cycle();
        check_output("rst_req",   {15'd0, imem_bus.imem_req}, 16'h0000);
        check_output("rst_valid", {15'd0, inst_valid}, 16'h0000);
        check_output("rst_inst",  inst, 16'h0000);
        check_output("rst_ilr",   ilr, 16'h0000);

        rst_n = 1'b1;
        #1;
        check_output("first_req",  {15'd0, imem_bus.imem_req}, 16'h0001);
        check_output("first_addr", imem_bus.imem_addr, 16'h0000);
        next_cycle();
        check_output("first_valid",   {15'd0, inst_valid}, 16'h0001);
        check_output("first_inst",    inst, 16'h1234);
        check_output("first_inst_pc", inst_pc, 16'h0000);
        next_cycle();
        check_output("seq_addr", imem_bus.imem_addr, 16'h0001);

        next_cycle();
        jmp_s = 1'b1; jmp_tgt = 16'h0010;
        next_cycle();
        jmp_s = 1'b0;
        check_output("jmp_addr", imem_bus.imem_addr, 16'h0010);
        next_cycle();
        check_output("beq_inst_pc", inst_pc, 16'h0010);
        beq_s = 1'b1; zero = 1'b1; br_off = 16'hFFFE;
        next_cycle();
        beq_s = 1'b0; zero = 1'b0;
        check_output("beq_taken", imem_bus.imem_addr, 16'h000F);

        next_cycle();
        jmp_s = 1'b1; jmp_tgt = 16'h0010;
        next_cycle();
        jmp_s = 1'b0;
        next_cycle();
        beq_s = 1'b1; zero = 1'b0;
        next_cycle();
        beq_s = 1'b0;
        check_output("beq_not_taken", imem_bus.imem_addr, 16'h0011);

        next_cycle();
        ret_s = 1'b1; jmp_s = 1'b1; ret_addr = 16'h0100; jmp_tgt = 16'h0200;
        next_cycle();
        ret_s = 1'b0; jmp_s = 1'b0;
        check_output("ret_over_jmp", imem_bus.imem_addr, 16'h0100);

        next_cycle();
        stall = 1'b1; jmp_s = 1'b1; jmp_tgt = 16'hFFFF;
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            check_output("stall_valid",   {15'd0, inst_valid}, 16'h0001);
            check_output("stall_inst_pc", inst_pc, 16'h0100);
            check_output("stall_req",     {15'd0, imem_bus.imem_req}, 16'h0000);
        end
        stall = 1'b0;
        next_cycle();
        jmp_s = 1'b0;
        check_output("jmp_ffff", imem_bus.imem_addr, 16'hFFFF);
        next_cycle();
        check_output("wrap_inst_pc", inst_pc, 16'hFFFF);
        next_cycle();
        check_output("wrap_addr", imem_bus.imem_addr, 16'h0000);

        next_cycle();
        jmp_s = 1'b1; jmp_tgt = 16'h0042;
        next_cycle();
        jmp_s = 1'b0;
        check_output("drain_start", imem_bus.imem_addr, 16'h0042);
        rdy_en = 1'b0; intr = 1'b1;
        next_cycle();
        intr = 1'b0;
        check_output("drain_addr1", imem_bus.imem_addr, 16'h0042);
        check_output("drain_ilr",   ilr, 16'h0042);
        next_cycle();
        check_output("drain_addr2", imem_bus.imem_addr, 16'h0042);
        intr = 1'b1;
        next_cycle();
        intr = 1'b0;
        check_output("drain_addr3", imem_bus.imem_addr, 16'h0042);
        rdy_en = 1'b1;
        next_cycle();
        check_output("drain_vec",   imem_bus.imem_addr, 16'h0002);
        check_output("drain_valid", {15'd0, inst_valid}, 16'h0000);
        check_output("drain_ilr2",  ilr, 16'h0042);
        next_cycle();
        check_output("vec_inst", inst, 16'h585A);

        intr = 1'b1; jmp_s = 1'b1; jmp_tgt = 16'h0300;
        next_cycle();
        intr = 1'b0; jmp_s = 1'b0;
        check_output("full_intr_addr",  imem_bus.imem_addr, 16'h0002);
        check_output("full_intr_ilr",   ilr, 16'h0002);
        check_output("full_intr_valid", {15'd0, inst_valid}, 16'h0000);

        next_cycle();
        b_s = 1'b1; br_off = 16'h0005;
        next_cycle();
        b_s = 1'b0;
        check_output("b_fwd", imem_bus.imem_addr, 16'h0008);
        intr = 1'b1;
        next_cycle();
        intr = 1'b0;
        check_output("fetch_intr_addr", imem_bus.imem_addr, 16'h0002);
        check_output("fetch_intr_ilr",  ilr, 16'h0008);

        next_cycle();
        next_cycle();
        check_output("pre_rst_addr", imem_bus.imem_addr, 16'h0003);
        rdy_en = 1'b0;
        next_cycle();
        #1;
        rst_n = 1'b0;
        #1;
        check_output("async_req",   {15'd0, imem_bus.imem_req}, 16'h0000);
        check_output("async_valid", {15'd0, inst_valid}, 16'h0000);
        check_output("async_ilr",   ilr, 16'h0000);
        next_cycle();
        next_cycle();
        rst_n = 1'b1; rdy_en = 1'b1;
        #1;
        check_output("restart_addr", imem_bus.imem_addr, 16'h0000);
        next_cycle();
        check_output("restart_inst", inst, 16'h1234);
        next_cycle();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
